// File: rtl/ones_sum_if.sv
// Valid/ready bundle for the ones' complement checksum engine.
// check_ok is present only when ONES_CHECK_EN is defined.
interface ones_sum_if #(
    parameter int CNT_W = 4
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       sum_out;
    logic [3:0]       checksum;
    logic [CNT_W-1:0] word_count;
    logic             trunc;
`ifdef ONES_CHECK_EN
    logic             check_ok;
`endif

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, sum_out, checksum, word_count, trunc
`ifdef ONES_CHECK_EN
        , input check_ok
`endif
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, sum_out, checksum, word_count, trunc
`ifdef ONES_CHECK_EN
        , output check_ok
`endif
    );
endinterface

// File: rtl/ones_sum_sequencer.sv
// 4-bit ones' complement checksum engine: ADD then FOLD per word.
// Define ONES_CHECK_EN to add the check_ok receiver-side output.
module ones_sum_sequencer #(
    parameter int MAX_WORDS = 8,
    parameter int CNT_W     = 4
) (
    input  logic     clk,
    input  logic     reset,
    ones_sum_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        FOLD,
        DONE
    } state_e;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_WORDS);

    state_e           state_q, state_d;
    logic [3:0]       acc_q, acc_d;
    logic [4:0]       tmp_q, tmp_d;
    logic             last_q, last_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trunc_q, trunc_d;
    logic             ready;
    logic             accept;

    assign ready  = (state_q == IDLE) || (state_q == WAIT);
    assign accept = bus.in_valid && ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            tmp_q   <= '0;
            last_q  <= 1'b0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            tmp_q   <= tmp_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        tmp_d   = tmp_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        trunc_d = trunc_q;
        unique case (state_q)
            IDLE, WAIT: begin
                if (accept) begin
                    tmp_d   = {1'b0, acc_q} + {1'b0, bus.in_data};
                    last_d  = bus.in_last;
                    cnt_d   = cnt_q + 1'b1;
                    state_d = FOLD;
                end
            end
            FOLD: begin
                // tmp peaks at 0x1E, so a single end-around carry is enough
                acc_d = tmp_q[3:0] + {3'b000, tmp_q[4]};
                if (last_q || (cnt_q == MAX_C)) begin
                    trunc_d = !last_q;
                    state_d = DONE;
                end else begin
                    state_d = WAIT;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    trunc_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.in_ready   = ready;
    assign bus.out_valid  = (state_q == DONE);
    assign bus.sum_out    = acc_q;
    assign bus.checksum   = ~acc_q;
    assign bus.word_count = cnt_q;
    assign bus.trunc      = trunc_q;
`ifdef ONES_CHECK_EN
    assign bus.check_ok   = (state_q == DONE) && (acc_q == 4'hF);
`endif
endmodule
